bram_port_arbiter: RTL and testbench

Shares one `bRAM` instance (independent write and read ports, registered 1-cycle read) between `nReq` requesters. Two independent round-robin arbiters run in each cycle: one for writes and one for reads. Grants are registered into the bRAM command ports. Read data is returned to all requesters on a shared response bus, tagged with the requester ID. The block sits between the parallel processing units and the storage they share, where a `mimobRAM` bank per unit would be too costly.

---
 rtl/bram_arb_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/bram_port_arbiter.sv | 110 +++++++++++
 tb/tb_bram_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg: shared types and the round-robin pick helper used by both
// arbiter instances of bram_port_arbiter.
//   cls_t   - request class (write / read)
//   pick_t  - {found, idx} result of a round-robin search
//   rr_pick - search candidates starting at ptr, wrapping from n-1 to 0
package bram_arb_pkg;

    typedef enum logic {
        CLS_WR,
        CLS_RD
    } cls_t;

    // Upper bound on requesters the pick helper can search.
    localparam int unsigned MaxReq = 32;
    localparam int unsigned IdxW   = $clog2(MaxReq);

    typedef struct packed {
        logic            found;
        logic [IdxW-1:0] idx;
    } pick_t;

    // First set candidate at or after ptr (circularly, over n entries).
    // ptr < n and k < n, so one conditional subtraction implements the wrap.
    function automatic pick_t rr_pick(input logic [MaxReq-1:0] cand,
                                      input int unsigned       ptr,
                                      input int unsigned       n);
        pick_t       res;
        int unsigned idx;
        res = '0;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if (k < n && !res.found && cand[idx[IdxW-1:0]]) begin
                res.found = 1'b1;
                res.idx   = idx[IdxW-1:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: single-class round-robin arbiter with its own search pointer.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointer -> 0)
//   cand        - requesters competing in this class
//   advance     - enables granting; with advance low no grant is issued and
//                 the pointer holds
//   gnt         - one-hot grant (combinational)
//   gnt_idx     - index of the granted requester (valid when |gnt)
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned nReq  = 4,
    parameter int unsigned idBit = $clog2(nReq) - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [nReq-1:0] cand,
    input  logic            advance,
    output logic [nReq-1:0] gnt,
    output logic [idBit:0]  gnt_idx
);

    localparam logic [idBit:0] LastIdx = (idBit + 1)'(nReq - 1);

    logic [idBit:0] ptr;
    pick_t          pick;
    logic           found;

    always_comb begin
        pick    = rr_pick(MaxReq'(cand), 32'(ptr), nReq);
        found   = pick.found & advance;
        gnt_idx = pick.idx[idBit:0];
        gnt     = '0;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (gnt_idx == LastIdx) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one simple-dual-port bRAM (1-cycle registered
// read) between nReq requesters. Independent round-robin arbiters serve the
// write port and the read port each cycle; read data returns on a shared bus
// tagged with the owner's ID, 2 cycles after the grant.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   req, req_we                - per-requester valid and write(1)/read(0)
//   req_addr, req_wd           - per-requester address and write data
//   gnt                        - combinational accept (<=1 write, <=1 read)
//   ram_we/ram_wa/ram_wd       - registered bRAM write port
//   ram_ra                     - registered bRAM read address
//   ram_rd                     - bRAM read data
//   rsp_valid/rsp_id/rsp_data  - read response (no backpressure)
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned nReq    = 4,
    parameter int unsigned datBit  = 17,
    parameter int unsigned addrBit = 9,
    parameter int unsigned idBit   = $clog2(nReq) - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [nReq-1:0]              req,
    input  logic [nReq-1:0]              req_we,
    input  logic [nReq-1:0][addrBit:0]   req_addr,
    input  logic [nReq-1:0][datBit:0]    req_wd,
    output logic [nReq-1:0]              gnt,
    output logic                         ram_we,
    output logic [addrBit:0]             ram_wa,
    output logic [datBit:0]              ram_wd,
    output logic [addrBit:0]             ram_ra,
    input  logic [datBit:0]              ram_rd,
    output logic                         rsp_valid,
    output logic [idBit:0]               rsp_id,
    output logic [datBit:0]              rsp_data
);

    logic [nReq-1:0] wr_gnt;
    logic [nReq-1:0] rd_gnt;
    logic [idBit:0]  wr_idx;
    logic [idBit:0]  rd_idx;
    logic            wr_any;
    logic            rd_any;

    // Response tag pipeline: stage 1 lines up with ram_ra, stage 2 with ram_rd.
    logic [1:0]      tag_valid;
    logic [idBit:0]  tag_id_s1;
    logic [idBit:0]  tag_id_s2;

    // advance tied to rst_n keeps gnt at 0 while reset is asserted.
    rr_arbiter #(
        .nReq  (nReq),
        .idBit (idBit)
    ) u_wr_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cand    (req & req_we),
        .advance (rst_n),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx)
    );

    rr_arbiter #(
        .nReq  (nReq),
        .idBit (idBit)
    ) u_rd_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .cand    (req & ~req_we),
        .advance (rst_n),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx)
    );

    always_comb begin
        wr_any = |wr_gnt;
        rd_any = |rd_gnt;
        gnt    = wr_gnt | rd_gnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we    <= 1'b0;
            ram_wa    <= '0;
            ram_wd    <= '0;
            ram_ra    <= '0;
            tag_valid <= '0;
            tag_id_s1 <= '0;
            tag_id_s2 <= '0;
        end else begin
            ram_we <= wr_any;
            if (wr_any) begin
                ram_wa <= req_addr[wr_idx];
                ram_wd <= req_wd[wr_idx];
            end
            if (rd_any) begin
                ram_ra <= req_addr[rd_idx];
            end
            tag_valid <= {tag_valid[0], rd_any};
            tag_id_s1 <= rd_idx;
            tag_id_s2 <= tag_id_s1;
        end
    end

    assign rsp_valid = tag_valid[1];
    assign rsp_id    = tag_id_s2;
    assign rsp_data  = ram_rd;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter: behavioural bRAM, reference model
// (round-robin pointers, reference memory, queue of due responses) compared
// every cycle, directed scenarios with literal expectations, then a random soak.
module tb_bram_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DB    = 17;
    localparam int AB    = 9;
    localparam int IB    = 1;
    localparam int DEPTH = 1024;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b1;
    logic [NREQ-1:0]        req    = '0;
    logic [NREQ-1:0]        req_we = '0;
    logic [NREQ-1:0][AB:0]  req_addr = '0;
    logic [NREQ-1:0][DB:0]  req_wd   = '0;
    logic [NREQ-1:0]        gnt;
    logic                   ram_we;
    logic [AB:0]            ram_wa;
    logic [DB:0]            ram_wd;
    logic [AB:0]            ram_ra;
    logic [DB:0]            ram_rd;
    logic                   rsp_valid;
    logic [IB:0]            rsp_id;
    logic [DB:0]            rsp_data;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .nReq    (NREQ),
        .datBit  (DB),
        .addrBit (AB),
        .idBit   (IB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wd    (req_wd),
        .gnt       (gnt),
        .ram_we    (ram_we),
        .ram_wa    (ram_wa),
        .ram_wd    (ram_wd),
        .ram_ra    (ram_ra),
        .ram_rd    (ram_rd),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    // Behavioural bRAM: registered read, read-before-write on collision.
    logic [DB:0] bram [DEPTH];
    always @(posedge clk) begin
        if (ram_we) bram[ram_wa] <= ram_wd;
        ram_rd <= bram[ram_ra];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Round-robin rule: first candidate at or after ptr, wrapping; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] c, input int ptr);
        int r = -1;
        for (int k = 0; k < NREQ; k++) begin
            int j = (ptr + k) % NREQ;
            if (r < 0 && c[j]) r = j;
        end
        return r;
    endfunction

    // ---------------- reference model + compare process ----------------
    typedef struct {
        int          due;
        int          id;
        logic [DB:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [DB:0] ref_mem [DEPTH];
    int          cyc = 0;
    bit          rst_seen = 1'b0;
    int          m_wptr = 0;
    int          m_rptr = 0;
    logic        e_we = 1'b0;
    logic [AB:0] e_wa = '0;
    logic [AB:0] e_ra = '0;
    logic [DB:0] e_wd = '0;
    int          wait_cnt [NREQ];

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(negedge clk) begin : compare
        int              wi;
        int              ri;
        logic [NREQ-1:0] eg;
        logic            dut_wr;
        logic            dut_rd;
        cyc++;
        if (!rst_n || rst_seen) begin
            rst_seen = 1'b0;
            m_wptr = 0;
            m_rptr = 0;
            exp_q.delete();
            e_we = 1'b0;
            e_wa = '0;
            e_wd = '0;
            e_ra = '0;
            for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        end
        if (!rst_n) begin
            check("rst_gnt", 64'(gnt), 64'(0));
            check("rst_ram_we", 64'(ram_we), 64'(0));
            check("rst_ram_wa", 64'(ram_wa), 64'(0));
            check("rst_ram_wd", 64'(ram_wd), 64'(0));
            check("rst_ram_ra", 64'(ram_ra), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_id", 64'(rsp_id), 64'(0));
        end else begin
            check("ram_we", 64'(ram_we), 64'(e_we));
            check("ram_wa", 64'(ram_wa), 64'(e_wa));
            check("ram_wd", 64'(ram_wd), 64'(e_wd));
            check("ram_ra", 64'(ram_ra), 64'(e_ra));
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                check("rsp_valid", 64'(rsp_valid), 64'(1));
                check("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                check("rsp_valid_idle", 64'(rsp_valid), 64'(0));
            end

            wi = pick(req & req_we, m_wptr);
            ri = pick(req & ~req_we, m_rptr);
            eg = '0;
            if (wi >= 0) eg[wi] = 1'b1;
            if (ri >= 0) eg[ri] = 1'b1;
            check("gnt", 64'(gnt), 64'(eg));

            // Fairness on the DUT's own grants: others of the same class
            // granted while a requester keeps waiting.
            dut_wr = |(gnt & req & req_we);
            dut_rd = |(gnt & req & ~req_we);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    wait_cnt[i] = 0;
                end else if (gnt[i]) begin
                    check("fair_wait", 64'((wait_cnt[i] <= NREQ - 1) ? 0 : wait_cnt[i]), 64'(0));
                    wait_cnt[i] = 0;
                end else if ((req_we[i] && dut_wr) || (!req_we[i] && dut_rd)) begin
                    wait_cnt[i]++;
                end
            end

            // Read sees memory before this cycle's write.
            if (ri >= 0) begin
                exp_q.push_back('{due: cyc + 2, id: ri, data: ref_mem[req_addr[2'(ri)]]});
                e_ra   = req_addr[2'(ri)];
                m_rptr = (ri + 1) % NREQ;
            end
            if (wi >= 0) begin
                ref_mem[req_addr[2'(wi)]] = req_wd[2'(wi)];
                e_we   = 1'b1;
                e_wa   = req_addr[2'(wi)];
                e_wd   = req_wd[2'(wi)];
                m_wptr = (wi + 1) % NREQ;
            end else begin
                e_we = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin : stim
        logic [NREQ-1:0] g;
        for (int i = 0; i < DEPTH; i++) begin
            bram[i]    = '0;
            ref_mem[i] = '0;
        end

        // Reset with everyone requesting reads.
        #1;
        rst_n  = 1'b0;
        req    = 4'b1111;
        req_we = 4'b0000;
        repeat (3) sample();
        check("lit_rst_gnt", 64'(gnt), 64'(0));
        check("lit_rst_rsp_valid", 64'(rsp_valid), 64'(0));

        // Round robin over continuous reads.
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) req_addr[i] = 10'(16 + i);
        for (int k = 0; k < 8; k++) begin
            sample();
            check("lit_rr_gnt", 64'(gnt), 64'(1) << (k % 4));
            if (k >= 2) begin
                check("lit_rr_rsp_valid", 64'(rsp_valid), 64'(1));
                check("lit_rr_rsp_id", 64'(rsp_id), 64'((k - 2) % 4));
            end
        end
        tick();
        req = '0;
        repeat (3) tick();

        // Seed addr 5 with a known old value, then concurrent write/read of addr 5.
        req = 4'b0001; req_we = 4'b0001; req_addr[0] = 10'd5; req_wd[0] = 18'h111;
        tick();
        req = '0;
        tick();
        req = 4'b0110; req_we = 4'b0010;
        req_addr[1] = 10'd5; req_wd[1] = 18'h2A; req_addr[2] = 10'd5;
        sample();
        check("lit_cc_gnt", 64'(gnt), 64'(4'b0110));
        tick();
        req = 4'b0100; req_we = 4'b0000;
        sample();
        check("lit_cc_regrant", 64'(gnt), 64'(4'b0100));
        tick();
        req = '0;
        sample();
        check("lit_cc_old_valid", 64'(rsp_valid), 64'(1));
        check("lit_cc_old_id", 64'(rsp_id), 64'(2));
        check("lit_cc_old_data", 64'(rsp_data), 64'(18'h111));
        tick();
        sample();
        check("lit_cc_new_valid", 64'(rsp_valid), 64'(1));
        check("lit_cc_new_data", 64'(rsp_data), 64'(18'h2A));
        tick();

        // Pointer hold / wrap: 3 alone, then 0 and 3 together.
        req = 4'b1000; req_we = 4'b1000; req_addr[3] = 10'd7; req_wd[3] = 18'h333;
        sample();
        check("lit_ph_first", 64'(gnt), 64'(4'b1000));
        tick();
        req = 4'b1001; req_we = 4'b1001;
        req_addr[0] = 10'd8; req_wd[0] = 18'h0AB; req_wd[3] = 18'h334;
        sample();
        check("lit_ph_wrap", 64'(gnt), 64'(4'b0001));
        tick();
        req = 4'b1000;
        sample();
        check("lit_ph_next", 64'(gnt), 64'(4'b1000));
        tick();
        req = '0;
        tick();

        // Reset while reads are in flight.
        req = 4'b0001; req_we = 4'b0000; req_addr[0] = 10'd20;
        sample();
        check("lit_rm_g0", 64'(gnt), 64'(4'b0001));
        tick();
        req = 4'b0010; req_addr[1] = 10'd21;
        sample();
        check("lit_rm_g1", 64'(gnt), 64'(4'b0010));
        #1 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req   = '0;
        sample();
        check("lit_rm_t2", 64'(rsp_valid), 64'(0));
        tick();
        sample();
        check("lit_rm_t3", 64'(rsp_valid), 64'(0));

        // Random soak: held until granted, small address range for collisions.
        g = '0;
        for (int c = 0; c < 10000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] || g[i]) begin
                    req[i]      = ($urandom_range(0, 99) < 60);
                    req_we[i]   = 1'($urandom_range(0, 1));
                    req_addr[i] = 10'($urandom_range(0, 15));
                    req_wd[i]   = 18'($urandom);
                end
            end
            sample();
            g = gnt & req;
        end
        tick();
        req = '0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
